// File: rtl/ps2_decodificador_teclas_pkg.sv
// Shared byte constants, FSM states and event layout for the PS/2 key decoder.
// Also used by the receiver and keymap blocks.
package ps2_decodificador_teclas_pkg;

    localparam logic [7:0] B_E0 = 8'hE0;
    localparam logic [7:0] B_F0 = 8'hF0;
    localparam logic [7:0] B_AA = 8'hAA;
    localparam logic [7:0] B_FA = 8'hFA;
    localparam logic [7:0] B_FE = 8'hFE;
    localparam logic [7:0] B_EE = 8'hEE;
    localparam logic [7:0] B_E1 = 8'hE1;
    localparam logic [7:0] B_00 = 8'h00;
    localparam logic [7:0] B_FF = 8'hFF;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_EXT    = 2'd1,
        ST_BRK    = 2'd2,
        ST_EXTBRK = 2'd3
    } state_e;

    typedef struct packed {
        logic       ext;
        logic       brk;
        logic [7:0] code;
    } evento_t;

    localparam int EV_W = $bits(evento_t);

    // 00/FF are keyboard error/overrun bytes
    function automatic logic es_error(input logic [7:0] b);
        return (b == B_00) || (b == B_FF);
    endfunction

    function automatic logic es_descarte(input logic [7:0] b);
        return es_error(b) || (b == B_AA) || (b == B_FA) ||
               (b == B_FE) || (b == B_EE) || (b == B_E1);
    endfunction

endpackage

// File: rtl/ps2_decodificador_teclas_if.sv
// Byte input / event FIFO bundle of the PS/2 key decoder.
interface ps2_decodificador_teclas_if #(
    parameter int FIFO_AW = 2
) ();
    logic             rx_done_tick;
    logic [7:0]       dato;
    logic             rd;
    logic [7:0]       key_code;
    logic             key_ext;
    logic             key_break;
    logic             empty;
    logic             full;
    logic [FIFO_AW:0] count;
    logic             overflow;

    modport master (
        output rx_done_tick, dato, rd,
        input  key_code, key_ext, key_break,
        input  empty, full, count, overflow
    );

    modport slave (
        input  rx_done_tick, dato, rd,
        output key_code, key_ext, key_break,
        output empty, full, count, overflow
    );
endinterface

// File: rtl/ps2_evento_fifo.sv
// Show-ahead event FIFO with occupancy count and sticky overflow flag.
module ps2_evento_fifo #(
    parameter int W  = 10,
    parameter int AW = 2
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          wr,
    input  logic [W-1:0]  wdata,
    input  logic          rd,
    output logic [W-1:0]  rdata,
    output logic          empty,
    output logic          full,
    output logic [AW:0]   count,
    output logic          overflow
);
    localparam int DEPTH = 1 << AW;

    logic [W-1:0]  mem_q [DEPTH];
    logic [AW-1:0] wp_q, wp_d;
    logic [AW-1:0] rp_q, rp_d;
    logic [AW:0]   cnt_q, cnt_d;
    logic          ovf_q, ovf_d;
    logic [W-1:0]  last_q;
    logic          do_rd, do_wr;

    always_comb begin
        empty = (cnt_q == '0);
        full  = (cnt_q == (AW+1)'(DEPTH));
        do_rd = rd & ~empty;
        // a full FIFO still accepts a write when a pop frees the slot
        do_wr = wr & (~full | do_rd);
        wp_d  = do_wr ? wp_q + 1'b1 : wp_q;
        rp_d  = do_rd ? rp_q + 1'b1 : rp_q;
        ovf_d = ovf_q | (wr & ~do_wr);
        unique case ({do_wr, do_rd})
            2'b10:   cnt_d = cnt_q + 1'b1;
            2'b01:   cnt_d = cnt_q - 1'b1;
            default: cnt_d = cnt_q;
        endcase
        rdata = empty ? last_q : mem_q[rp_q];
    end

    always_ff @(posedge clk) begin
        if (do_wr) mem_q[wp_q] <= wdata;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wp_q   <= '0;
            rp_q   <= '0;
            cnt_q  <= '0;
            ovf_q  <= 1'b0;
            last_q <= '0;
        end else begin
            wp_q   <= wp_d;
            rp_q   <= rp_d;
            cnt_q  <= cnt_d;
            ovf_q  <= ovf_d;
            last_q <= rdata;
        end
    end

    assign count    = cnt_q;
    assign overflow = ovf_q;

endmodule

// File: rtl/ps2_decodificador_teclas.sv
// PS/2 scan-code decoder: folds E0/F0 prefixes into key events and
// queues them; stale prefixes are dropped after TIMEOUT_CYC idle cycles.
module ps2_decodificador_teclas
    import ps2_decodificador_teclas_pkg::*;
#(
    parameter int FIFO_AW     = 2,
    parameter int TIMEOUT_CYC = 2_000_000
) (
    input  logic                         clk_nexys,
    input  logic                         reset,
    ps2_decodificador_teclas_if.slave    bus
);
    localparam int TMO_W = $clog2(TIMEOUT_CYC);
    localparam logic [TMO_W-1:0] TMO_MAX = TMO_W'(TIMEOUT_CYC - 1);

    state_e           state_q, state_d;
    logic [TMO_W-1:0] tmo_q, tmo_d;
    logic             ev_wr;
    evento_t          ev;
    evento_t          head;

    always_comb begin
        state_d = state_q;
        tmo_d   = tmo_q;
        ev_wr   = 1'b0;
        ev      = '{ext: 1'b0, brk: 1'b0, code: bus.dato};
        if (bus.rx_done_tick) begin
            tmo_d = '0;
            unique case (state_q)
                ST_IDLE: begin
                    if (bus.dato == B_E0)           state_d = ST_EXT;
                    else if (bus.dato == B_F0)      state_d = ST_BRK;
                    else if (!es_descarte(bus.dato)) ev_wr  = 1'b1;
                end
                ST_EXT: begin
                    if (bus.dato == B_F0)        state_d = ST_EXTBRK;
                    else if (bus.dato == B_E0)   state_d = ST_EXT;
                    else if (es_error(bus.dato)) state_d = ST_IDLE;
                    else begin
                        ev_wr   = 1'b1;
                        ev.ext  = 1'b1;
                        state_d = ST_IDLE;
                    end
                end
                ST_BRK, ST_EXTBRK: begin
                    state_d = ST_IDLE;
                    if (!(es_error(bus.dato) || bus.dato == B_E0 ||
                          bus.dato == B_F0)) begin
                        ev_wr  = 1'b1;
                        ev.ext = (state_q == ST_EXTBRK);
                        ev.brk = 1'b1;
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end else if (state_q == ST_IDLE) begin
            tmo_d = '0;
        end else if (tmo_q == TMO_MAX) begin
            // prefix went stale: drop it silently
            tmo_d   = '0;
            state_d = ST_IDLE;
        end else begin
            tmo_d = tmo_q + 1'b1;
        end
    end

    always_ff @(posedge clk_nexys or negedge reset) begin
        if (!reset) begin
            state_q <= ST_IDLE;
            tmo_q   <= '0;
        end else begin
            state_q <= state_d;
            tmo_q   <= tmo_d;
        end
    end

    ps2_evento_fifo #(
        .W  (EV_W),
        .AW (FIFO_AW)
    ) u_fifo (
        .clk      (clk_nexys),
        .rst_n    (reset),
        .wr       (ev_wr),
        .wdata    (ev),
        .rd       (bus.rd),
        .rdata    (head),
        .empty    (bus.empty),
        .full     (bus.full),
        .count    (bus.count),
        .overflow (bus.overflow)
    );

    assign bus.key_code  = head.code;
    assign bus.key_ext   = head.ext;
    assign bus.key_break = head.brk;

endmodule
